// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out frame transmitter with clock enable and asynchronous clear.
// Optional macro PISO_SHIFT_PARITY_EN appends one even-parity bit after the data bits.
module piso_shift_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             q,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef PISO_SHIFT_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             q_d, busy_d, done_d;
`ifdef PISO_SHIFT_PARITY_EN
  logic             par, par_d;
`endif

  // The bit leaving next always sits at the output end of the shift register.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  always_comb begin
    // NOTE: every next value defaults to the current one before the case, so no latch can be inferred.
    state_d = state;
    sreg_d  = sreg;
    cnt_d   = cnt;
    q_d     = q;
    busy_d  = busy;
    done_d  = done;
`ifdef PISO_SHIFT_PARITY_EN
    par_d   = par;
`endif

    case (state)
      IDLE: begin
        q_d    = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (load) begin
          q_d     = head(din);
          sreg_d  = advance(din);
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef PISO_SHIFT_PARITY_EN
          par_d   = ^din;
`endif
        end
      end

      SHIFT: begin
        if (cnt < CNT_LAST) begin
          q_d    = head(sreg);
          sreg_d = advance(sreg);
          cnt_d  = cnt + CNT_ONE;
        end else begin
`ifdef PISO_SHIFT_PARITY_EN
          q_d     = par;
          state_d = PAR;
`else
          q_d     = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
`endif
        end
      end

`ifdef PISO_SHIFT_PARITY_EN
      PAR: begin
        q_d     = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
`endif

      DONE: begin
        q_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cnt_d   = '0;
        sreg_d  = '0;
        state_d = IDLE;
      end

      default: begin
        q_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cnt_d   = '0;
        sreg_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Clear aborts any frame at once; en=0 freezes everything, including a done pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      // NOTE: the shift register is a plain register, not a memory, so it is cleared with the rest of the state.
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      q     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef PISO_SHIFT_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (en) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state <= state_d;
      sreg  <= sreg_d;
      cnt   <= cnt_d;
      q     <= q_d;
      busy  <= busy_d;
      done  <= done_d;
`ifdef PISO_SHIFT_PARITY_EN
      par   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: an MSB-first and an LSB-first instance share stimulus
// and are compared against a per-frame expected sequence built from the frame rules.
module tb_piso_shift_tx;

  localparam int W = 8;
`ifdef PISO_SHIFT_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // Observations per frame: W data bits, optional parity, DONE, then one IDLE.
  localparam int L = W + P + 2;

  logic         clk = 1'b0;
  logic         clr;
  logic         en;
  logic         load;
  logic [W-1:0] din;
  logic         q_m, busy_m, done_m;
  logic         q_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .clr(clr), .en(en), .load(load), .din(din),
    .q(q_m), .busy(busy_m), .done(done_m)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .clr(clr), .en(en), .load(load), .din(din),
    .q(q_l), .busy(busy_l), .done(done_l)
  );

  // Expected {q, busy, done} i enabled edges after the edge that accepted load.
  function automatic logic [2:0] model(input logic [W-1:0] d, input bit msb, input int i);
    int   pos;
    logic b;
    if (i < W) begin
      pos = msb ? (W - 1 - i) : i;
      b   = ((d >> pos) % 2) != 0;
      return {b, 2'b10};
    end
    if (P == 1 && i == W) begin
      b = ($countones(d) % 2) != 0;
      return {b, 2'b10};
    end
    if (i == W + P) return 3'b011;
    return 3'b000;
  endfunction

  // Drives one frame from an idle negedge and checks every observation on both instances.
  // noise: 0 = load low while busy, 1 = random load/din while busy, 2 = load high with din all ones.
  task automatic run_frame(input logic [W-1:0] d, input int stall_at, input int stall_len,
                           input int noise, input string tag);
    logic [2:0] exp_m, exp_l;
    load = 1'b1;
    din  = d;
    en   = 1'b1;
    for (int i = 0; i < L; i++) begin
      int reps;
      reps  = (i == stall_at) ? stall_len + 1 : 1;
      exp_m = model(d, 1'b1, i);
      exp_l = model(d, 1'b0, i);
      for (int r = 0; r < reps; r++) begin
        @(negedge clk);
        checks++;
        if ({q_m, busy_m, done_m} !== exp_m) begin
          errors++;
          $display("FAIL %s msb idx=%0d rep=%0d got q,busy,done=%b expected %b",
                   tag, i, r, {q_m, busy_m, done_m}, exp_m);
        end
        checks++;
        if ({q_l, busy_l, done_l} !== exp_l) begin
          errors++;
          $display("FAIL %s lsb idx=%0d rep=%0d got q,busy,done=%b expected %b",
                   tag, i, r, {q_l, busy_l, done_l}, exp_l);
        end
        en = (r < reps - 1) ? 1'b0 : 1'b1;
        if (r == 0) begin
          if (i == L - 1 || noise == 0) begin
            load = 1'b0;
          end else if (noise == 1) begin
            load = 1'($urandom_range(0, 1));
            din  = W'($urandom);
          end else begin
            load = 1'b1;
            din  = '1;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    clr  = 1'b1;
    en   = 1'b1;
    load = 1'b1;
    din  = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({q_m, busy_m, done_m, q_l, busy_l, done_l} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold got %b expected 000000",
               {q_m, busy_m, done_m, q_l, busy_l, done_l});
    end
    load = 1'b0;
    clr  = 1'b0;
    @(negedge clk);
    checks++;
    if ({q_m, busy_m, done_m, q_l, busy_l, done_l} !== 6'b0) begin
      errors++;
      $display("FAIL reset_release got %b expected 000000",
               {q_m, busy_m, done_m, q_l, busy_l, done_l});
    end
  endtask

  task automatic test_basic();
    run_frame(8'hA5, -1, 0, 0, "basic_a5");
    run_frame(8'h01, -1, 0, 0, "basic_01");
  endtask

  task automatic test_enable();
    en   = 1'b0;
    load = 1'b1;
    din  = 8'h81;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy_m, busy_l, q_m, q_l} !== 4'b0) begin
        errors++;
        $display("FAIL enable_idle_hold got busy/q=%b expected 0000", {busy_m, busy_l, q_m, q_l});
      end
    end
    load = 1'b0;
    en   = 1'b1;
    @(negedge clk);
    run_frame(8'hF0, 2, 3, 0, "stall_f0");
    run_frame(8'h96, W, 2, 0, "stall_in_done");
  endtask

  task automatic test_abort();
    logic [2:0] exp_m;
    load = 1'b1;
    din  = 8'h5A;
    en   = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      exp_m = model(8'h5A, 1'b1, i);
      @(negedge clk);
      checks++;
      if ({q_m, busy_m, done_m} !== exp_m) begin
        errors++;
        $display("FAIL abort_pre idx=%0d got %b expected %b", i, {q_m, busy_m, done_m}, exp_m);
      end
      load = 1'b0;
    end
    #1 clr = 1'b1;
    #2;
    checks++;
    if ({q_m, busy_m, done_m, q_l, busy_l, done_l} !== 6'b0) begin
      errors++;
      $display("FAIL abort_async got %b expected 000000",
               {q_m, busy_m, done_m, q_l, busy_l, done_l});
    end
    #8 clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({q_m, busy_m, done_m, q_l, busy_l, done_l} !== 6'b0) begin
      errors++;
      $display("FAIL abort_after got %b expected 000000",
               {q_m, busy_m, done_m, q_l, busy_l, done_l});
    end
    run_frame(8'h3C, -1, 0, 0, "after_abort_3c");
  endtask

  task automatic test_load_ignored();
    run_frame(8'h00, -1, 0, 2, "reload_00");
  endtask

  task automatic test_back_to_back();
    run_frame(8'hC3, -1, 0, 1, "b2b_first");
    run_frame(8'h4E, -1, 0, 1, "b2b_second");
  endtask

  task automatic test_parity();
    run_frame(8'h07, -1, 0, 0, "parity_07");
    run_frame(8'h03, -1, 0, 0, "parity_03");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int sa, sl, nz;
      sa = $urandom_range(0, 2 * L);
      sl = $urandom_range(1, 3);
      nz = $urandom_range(0, 1);
      run_frame(W'($urandom), sa, sl, nz, $sformatf("random_%0d", n));
    end
  endtask

  initial begin
    clr  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    din  = '0;
    test_reset();
    test_basic();
    test_enable();
    test_abort();
    test_load_ignored();
    test_back_to_back();
    test_parity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1; 1 = din[WIDTH-1] transmitted first, 0 = din[0] transmitted first.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  clock enable; when 0 all state and outputs hold.
REQ-006 load  input  1  frame start request, sampled on enabled edges.
REQ-007 din  input  WIDTH  parallel frame data, sampled on the edge that accepts load.
REQ-008 q  output  1  registered serial data out; idle level 0.
REQ-009 busy  output  1  registered; high while a frame is in progress (SHIFT, PAR, DONE states).
REQ-010 done  output  1  registered; one-enabled-cycle pulse at end of frame.

Function
REQ-011 FSM states: IDLE, SHIFT, PAR (present only with parity compiled in), DONE; an enabled edge is a rising clk edge with en=1.
REQ-012 IDLE: q=0, busy=0, done=0; on an enabled edge with load=1, capture din, drive q with the first bit, set bit counter to 1, go to SHIFT, busy=1.
REQ-013 IDLE with load=0: remain in IDLE, outputs unchanged.
REQ-014 SHIFT: each enabled edge with counter<WIDTH drives q with the next bit in order and increments the counter.
REQ-015 SHIFT with counter=WIDTH: next enabled edge goes to DONE (parity off) or PAR (parity on).
REQ-016 Timing: with load accepted at enabled edge N, bit k (k=0..WIDTH-1) is held on q from edge N+k until edge N+k+1.
REQ-017 DONE entered at edge N+WIDTH (parity off) or N+WIDTH+1 (parity on): q=0, done=1, busy=1.
REQ-018 DONE: next enabled edge returns to IDLE with done=0, busy=0.
REQ-019 load while busy=1 (SHIFT, PAR, DONE) is ignored; din changes during a frame have no effect.
REQ-020 en=0 at any point freezes state, counter, shift register, q, busy and done; the frame resumes unchanged when en returns to 1; a done pulse lasts one enabled cycle, i.e. stretches across en=0 cycles.
REQ-021 Back-to-back frames: minimum one IDLE cycle between frames; load held high in IDLE starts the next frame on the first enabled edge in IDLE.
REQ-022 Counter width is ceil(log2(WIDTH+1)) bits; no wrap-around permitted within a frame.

Reset
REQ-023 clr=1 immediately, independent of clk and en, forces IDLE, q=0, busy=0, done=0, shift register=0, counter=0.
REQ-024 clr asserted mid-frame aborts the frame with no done pulse; after clr deasserts, the first enabled edge with load=1 starts a fresh frame.
REQ-025 While clr=1, load is ignored.

Configuration
REQ-026 Macro PISO_SHIFT_PARITY_EN: when defined, PAR state appends one even-parity bit (XOR of all WIDTH captured bits) on q for one enabled cycle after the last data bit, extending busy by one cycle.
REQ-027 Without PISO_SHIFT_PARITY_EN: no PAR state exists, SHIFT goes directly to DONE, frame length WIDTH bits.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, parity off, en=1, load pulse with din=8'hA5 -> q=1,0,1,0,0,1,0,1 on edges N..N+7; done=1 only after edge N+8; busy=0 after edge N+9.
REQ-029 MSB_FIRST=0, din=8'hA5 -> q=1,0,1,0,0,1,0,1 (LSB first, same bit pattern since A5 is a palindrome); repeat with din=8'h01 -> q=1 then seven 0s.
REQ-030 din=8'hF0, en dropped to 0 for 3 cycles after bit 2 -> q holds bit 2 (1) for 4 total cycles; remaining bits 1,0,0,0,0 follow; single done pulse.
REQ-031 clr pulsed for 10 time units between bit 4 and bit 5 of a frame -> q=0, busy=0 immediately, no done pulse; next load with din=8'h3C transmits 0,0,1,1,1,1,0,0 correctly.
REQ-032 load re-asserted with din=8'hFF during SHIFT of frame 8'h00 -> ignored, q stays 0 for all 8 bits, exactly one done pulse.
REQ-033 PISO_SHIFT_PARITY_EN defined, din=8'h07 -> data bits then parity bit q=1 after edge N+8; done after edge N+9; din=8'h03 -> parity bit 0.
